// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(2^SYM_W).
// Message symbols pass straight through. After the message, NPAR parity
// symbols are drained from an LFSR polynomial divider.
// Optional feature macro: RS_ENC_SHORTEN_EN adds an s_last input that ends
// the message early, giving a shortened code.
module rs_stream_encoder #(
  parameter int                         SYM_W     = 4,
  parameter int                         N         = 15,
  parameter int                         K         = 11,
  parameter logic [SYM_W:0]             PRIM_POLY = 5'h13,
  parameter logic [(N-K)*SYM_W-1:0]     GEN_POLY  = 16'hDC87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
`ifdef RS_ENC_SHORTEN_EN
  input  logic             s_last,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SYM_W-1:0] m_data,
  output logic             m_parity,
  output logic             m_last,
  output logic [15:0]      cw_count
);

  localparam int NPAR  = N - K;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {S_DATA, S_PARITY} state_t;

  state_t                         state_q;
  logic [CNT_W-1:0]               sym_cnt_q;
  logic [NPAR-1:0][SYM_W-1:0]     par_q;
  logic [NPAR-1:0][SYM_W-1:0]     par_acc_d;
  logic [NPAR-1:0][SYM_W-1:0]     par_shift_d;
  logic                           m_valid_q;
  logic [SYM_W-1:0]               m_data_q;
  logic                           m_parity_q;
  logic                           m_last_q;
  logic [15:0]                    cw_count_q;
  logic [SYM_W-1:0]               fb;
  logic                           out_free;
  logic                           accept;
  logic                           last_msg;
  logic                           last_par;

  // GF(2^SYM_W) multiply: shift-and-add with reduction by the primitive polynomial
  function automatic logic [SYM_W-1:0] gfmul(input logic [SYM_W-1:0] a,
                                             input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ aa;
      if (aa[SYM_W-1]) aa = (aa << 1) ^ PRIM_POLY[SYM_W-1:0];
      else             aa = aa << 1;
    end
    return p;
  endfunction

  assign out_free = !m_valid_q || m_ready;
  assign s_ready  = (state_q == S_DATA) && out_free && !rst;
  assign accept   = s_valid && s_ready;
  assign fb       = s_data ^ par_q[NPAR-1];
  assign last_par = (sym_cnt_q == CNT_W'(NPAR - 1));

`ifdef RS_ENC_SHORTEN_EN
  // A flagged symbol closes the message early; the K-th symbol always does
  assign last_msg = (sym_cnt_q == CNT_W'(K - 1)) || s_last;
`else
  assign last_msg = (sym_cnt_q == CNT_W'(K - 1));
`endif

  // Next divider contents: feedback step on accept, plain shift while draining
  always_comb begin
    par_acc_d   = '0;
    par_shift_d = '0;
    par_acc_d[0] = gfmul(fb, GEN_POLY[SYM_W-1:0]);
    for (int i = 1; i < NPAR; i++) begin
      par_acc_d[i]   = par_q[i-1] ^ gfmul(fb, GEN_POLY[i*SYM_W +: SYM_W]);
      par_shift_d[i] = par_q[i-1];
    end
  end

  // Control FSM, divider state and single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DATA;
      sym_cnt_q  <= '0;
      par_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_parity_q <= 1'b0;
      m_last_q   <= 1'b0;
      cw_count_q <= '0;
    end else begin
      if (m_valid_q && m_ready && m_last_q) cw_count_q <= cw_count_q + 16'd1;

      if (accept) begin
        par_q      <= par_acc_d;
        m_valid_q  <= 1'b1;
        m_data_q   <= s_data;
        m_parity_q <= 1'b0;
        m_last_q   <= 1'b0;
        if (last_msg) begin
          state_q   <= S_PARITY;
          sym_cnt_q <= '0;
        end else begin
          sym_cnt_q <= sym_cnt_q + 1'b1;
        end
      end else if (state_q == S_PARITY && out_free) begin
        // After NPAR shifts the divider is naturally back to all-zero
        par_q      <= par_shift_d;
        m_valid_q  <= 1'b1;
        m_data_q   <= par_q[NPAR-1];
        m_parity_q <= 1'b1;
        m_last_q   <= last_par;
        if (last_par) begin
          state_q   <= S_DATA;
          sym_cnt_q <= '0;
        end else begin
          sym_cnt_q <= sym_cnt_q + 1'b1;
        end
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_parity = m_parity_q;
  assign m_last   = m_last_q;
  assign cw_count = cw_count_q;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Self-checking bench for rs_stream_encoder (RS(15,11) over GF(16)).
// Expected codewords come from a long-division RS model pushed to a queue.
module tb_rs_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_data;
  logic        m_parity;
  logic        m_last;
  logic [15:0] cw_count;
`ifdef RS_ENC_SHORTEN_EN
  logic        s_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int stall_out = 0;
  logic [5:0] exp_q[$];   // {last, parity, data}

  rs_stream_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
`ifdef RS_ENC_SHORTEN_EN
    .s_last   (s_last),
`endif
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_parity (m_parity),
    .m_last   (m_last),
    .cw_count (cw_count)
  );

  always #5 clk = ~clk;

  // Downstream backpressure generator
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (stall_out == 0) || ($urandom_range(0, 99) >= stall_out);
    end
  end

  // GF(16) multiply, Horner form over the bits of a
  function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    p = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      p = p[3] ? ((p << 1) ^ 4'h3) : (p << 1);
      if (a[i]) p = p ^ b;
    end
    return p;
  endfunction

  // Reference: remainder of msg(x)*x^4 divided by g(x), by long division
  function automatic void push_cw(input logic [3:0] msg[$]);
    logic [3:0] d[$];
    logic [3:0] g[5];
    logic [3:0] c;
    int L;
    g[0] = 4'h1; g[1] = 4'hD; g[2] = 4'hC; g[3] = 4'h8; g[4] = 4'h7;
    d = msg;
    L = msg.size();
    repeat (4) d.push_back(4'h0);
    for (int i = 0; i < L; i++) begin
      c = d[i];
      for (int j = 1; j <= 4; j++) d[i+j] = d[i+j] ^ gm(c, g[j]);
    end
    for (int i = 0; i < L; i++) exp_q.push_back({2'b00, msg[i]});
    for (int j = 0; j < 4; j++) exp_q.push_back({(j == 3), 1'b1, d[L+j]});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 4'h0;
`ifdef RS_ENC_SHORTEN_EN
    s_last = 1'b0;
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic [3:0] msg[$], input int stall, input bit last_flag);
    bit acc;
    int cyc;
    for (int i = 0; i < msg.size(); i++) begin
      s_data = msg[i];
`ifdef RS_ENC_SHORTEN_EN
      s_last = last_flag && (i == msg.size() - 1);
`endif
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 500) begin
        s_valid = (stall == 0) || ($urandom_range(0, 99) >= stall);
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        n_fail++;
        $display("FAIL drive_timeout: symbol %0d not accepted within %0d cycles", i, cyc);
      end
    end
    s_valid = 1'b0;
`ifdef RS_ENC_SHORTEN_EN
    s_last = 1'b0;
`endif
  endtask

  task automatic collect(input int n, input bit no_bubble, input int budget);
    int got = 0, cyc = 0, bubbles = 0;
    bit started = 0, hold = 0;
    logic [5:0] prev = '0, act, e;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      act = {m_last, m_parity, m_data};
      if (hold) begin
        n_checks++;
        if (m_valid !== 1'b1 || act !== prev) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_valid, act, prev);
        end
      end
      if (m_valid && m_parity && !m_last) begin
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_in_parity: s_ready=%b expected 0", s_ready);
        end
      end
      if (started && !m_valid) bubbles++;
      if (m_valid && m_ready) begin
        started = 1;
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output: got %h expected nothing", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL out_sym%0d: got {last,par,data}=%h expected %h", got, act, e);
          end
        end
      end
      hold = m_valid && !m_ready;
      prev = act;
    end
    n_checks++;
    if (got < n) begin
      n_fail++;
      $display("FAIL collect_timeout: got %0d symbols expected %0d", got, n);
    end
    if (no_bubble) begin
      n_checks++;
      if (bubbles != 0) begin
        n_fail++;
        $display("FAIL bubbles: got %0d expected 0", bubbles);
      end
    end
  endtask

  task automatic check_tail(input logic [15:0] exp_cw);
    @(posedge clk);
    #1;
    n_checks++;
    if (cw_count !== exp_cw) begin
      n_fail++;
      $display("FAIL cw_count: got %0d expected %0d", cw_count, exp_cw);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 4'hF;
`ifdef RS_ENC_SHORTEN_EN
    s_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_ready, m_valid, m_data, m_parity, m_last} !== 8'h00 || cw_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h p=%b l=%b cw=%0d expected all 0",
               s_ready, m_valid, m_data, m_parity, m_last, cw_count);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_msg();
    logic [3:0] msg[$];
    do_reset();
    stall_out = 0;
    repeat (11) msg.push_back(4'h0);
    push_cw(msg);
    fork
      drive(msg, 0, 1'b0);
      collect(15, 1'b0, 200);
    join
    check_tail(16'd1);
  endtask

  task automatic test_single_one();
    logic [3:0] msg[$];
    do_reset();
    stall_out = 0;
    repeat (10) msg.push_back(4'h0);
    msg.push_back(4'h1);
    // Hand-written expected codeword as an anchor independent of the model
    for (int i = 0; i < 10; i++) exp_q.push_back(6'h00);
    exp_q.push_back(6'h01);
    exp_q.push_back(6'h1D);
    exp_q.push_back(6'h1C);
    exp_q.push_back(6'h18);
    exp_q.push_back(6'h37);
    fork
      drive(msg, 0, 1'b0);
      collect(15, 1'b0, 200);
    join
    check_tail(16'd1);
  endtask

  task automatic test_random();
    logic [3:0] msg[$];
    logic [3:0] all[$];
    do_reset();
    stall_out = 30;
    for (int c = 0; c < 4; c++) begin
      msg.delete();
      repeat (11) msg.push_back(4'($urandom_range(0, 15)));
      push_cw(msg);
      all = {all, msg};
    end
    fork
      drive(all, 30, 1'b0);
      collect(60, 1'b0, 3000);
    join
    stall_out = 0;
    check_tail(16'd4);
  endtask

  task automatic test_back_to_back();
    logic [3:0] m0[$];
    logic [3:0] m1[$];
    do_reset();
    stall_out = 0;
    repeat (11) m0.push_back(4'($urandom_range(0, 15)));
    repeat (11) m1.push_back(4'($urandom_range(0, 15)));
    push_cw(m0);
    push_cw(m1);
    fork
      begin
        drive(m0, 0, 1'b0);
        drive(m1, 0, 1'b0);
      end
      collect(30, 1'b1, 300);
    join
    check_tail(16'd2);
  endtask

  task automatic test_mid_reset();
    logic [3:0] junk[$];
    logic [3:0] msg[$];
    do_reset();
    stall_out = 0;
    repeat (5) junk.push_back(4'($urandom_range(1, 15)));
    drive(junk, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || cw_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got v=%b cw=%0d expected v=0 cw=0", m_valid, cw_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) msg.push_back(4'h0);
    msg.push_back(4'h1);
    push_cw(msg);
    fork
      drive(msg, 0, 1'b0);
      collect(15, 1'b0, 200);
    join
    check_tail(16'd1);
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got v=%b expected 0", m_valid);
    end
  endtask

`ifdef RS_ENC_SHORTEN_EN
  task automatic test_shorten();
    logic [3:0] msg[$];
    logic [3:0] m2[$];
    do_reset();
    stall_out = 0;
    msg.push_back(4'h1);
    exp_q.push_back(6'h01);
    exp_q.push_back(6'h1D);
    exp_q.push_back(6'h1C);
    exp_q.push_back(6'h18);
    exp_q.push_back(6'h37);
    repeat (6) m2.push_back(4'($urandom_range(0, 15)));
    push_cw(m2);
    fork
      begin
        drive(msg, 0, 1'b1);
        drive(m2, 20, 1'b1);
      end
      collect(15, 1'b0, 500);
    join
    check_tail(16'd2);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_msg();
    test_single_one();
    test_random();
    test_back_to_back();
    test_mid_reset();
`ifdef RS_ENC_SHORTEN_EN
    test_shorten();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
